// File: rtl/branch_redirect.sv
// Branch misprediction recovery: queues the fall-through PCs of predicted-taken
// branches and redirects fetch to the oldest one when its branch fails in EX.
module branch_redirect #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_branch_valid,
  input  logic [31:0]      id_fallthrough_pc,
  input  logic             ex_branch,
  input  logic             ex_fail,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt,
  output logic             err_overflow,
  output logic             err_underflow
);

  typedef enum logic {NORMAL, FLUSH} state_t;

  state_t             state_q, state_d;
  logic [31:0]        mem_q [2];
  logic               head_q, head_d;
  logic [1:0]         count_q, count_d;
  logic               redirect_valid_q, redirect_valid_d;
  logic               flush_q, flush_d;
  logic [31:0]        redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0]   branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]   mispredict_cnt_q, mispredict_cnt_d;
  logic               err_overflow_q, err_overflow_d;
  logic               err_underflow_q, err_underflow_d;
  logic               wr_en;
  logic               wr_idx;
  logic               pop;
  logic               push_ok;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    state_d          = state_q;
    head_d           = head_q;
    count_d          = count_q;
    redirect_valid_d = 1'b0;
    flush_d          = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    err_overflow_d   = err_overflow_q;
    err_underflow_d  = err_underflow_q;
    wr_en            = 1'b0;
    wr_idx           = head_q ^ count_q[0];
    pop              = ex_branch && (count_q != 2'd0);
    push_ok          = 1'b0;

    case (state_q)
      NORMAL: begin
        if (ex_branch) begin
          branch_cnt_d = sat_inc(branch_cnt_q);
          if (count_q == 2'd0) err_underflow_d = 1'b1;
        end
        if (pop && ex_fail) begin
          // Any same-cycle push is on the wrong path and is discarded with the queue.
          redirect_pc_d    = mem_q[head_q];
          redirect_valid_d = 1'b1;
          flush_d          = 1'b1;
          mispredict_cnt_d = sat_inc(mispredict_cnt_q);
          count_d          = 2'd0;
          state_d          = FLUSH;
        end else begin
          push_ok = id_branch_valid && ((count_q != 2'd2) || pop);
          if (id_branch_valid && (count_q == 2'd2) && !pop) err_overflow_d = 1'b1;
          wr_en   = push_ok;
          head_d  = pop ? ~head_q : head_q;
          count_d = count_q + {1'b0, push_ok} - {1'b0, pop};
        end
      end
      FLUSH: state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= NORMAL;
      head_q           <= 1'b0;
      count_q          <= 2'd0;
      redirect_valid_q <= 1'b0;
      flush_q          <= 1'b0;
      redirect_pc_q    <= 32'd0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
      err_overflow_q   <= 1'b0;
      err_underflow_q  <= 1'b0;
    end else begin
      state_q          <= state_d;
      head_q           <= head_d;
      count_q          <= count_d;
      redirect_valid_q <= redirect_valid_d;
      flush_q          <= flush_d;
      redirect_pc_q    <= redirect_pc_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
      err_overflow_q   <= err_overflow_d;
      err_underflow_q  <= err_underflow_d;
    end
  end

  // Queue storage carries data only; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= id_fallthrough_pc;
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;
  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;
  assign err_overflow   = err_overflow_q;
  assign err_underflow  = err_underflow_q;

endmodule
